// File: rtl/jt63701_romrq_if.sv
// jt63701_romrq_if: MCU PROM request bus and SDRAM fetch slot seen by the ROM responder.
interface jt63701_romrq_if #(parameter int AW = 14);
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          rom_ok;
  logic          flush;
  logic [AW-2:0] sd_addr;
  logic          sd_req;
  logic          sd_ack;
  logic          sd_dok;
  logic [15:0]   sd_data;
  modport slave (
    input  rom_cs, rom_addr, flush, sd_ack, sd_dok, sd_data,
    output rom_data, rom_ok, sd_addr, sd_req
  );
  modport master (
    output rom_cs, rom_addr, flush, sd_ack, sd_dok, sd_data,
    input  rom_data, rom_ok, sd_addr, sd_req
  );
endinterface

// File: rtl/jt63701_romrq.sv
// jt63701_romrq: byte PROM responder backed by a 2-word cache with sequential prefetch over SDRAM.
module jt63701_romrq #(
  parameter int AW       = 14,
  parameter bit PREFETCH = 1'b1
) (
  input logic             clk,
  input logic             rst,
  jt63701_romrq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} st_t;
  st_t           st_q, st_d;
  logic          req_q, req_d, lru_q, lru_d, discard_q, discard_d;
  logic [AW-2:0] addr_q, addr_d;
  logic [1:0]    valid_q, valid_d;
  logic [AW-2:0] tag_q [2];
  logic [AW-2:0] tag_d [2];
  logic [15:0]   data_q [2];
  logic [15:0]   data_d [2];
  logic [AW-2:0] tag, nxt;
  logic          h0, h1, hit, nxt_cached;
  logic [15:0]   word;
  always_comb begin
    tag        = bus.rom_addr[AW-1:1];
    nxt        = tag + (AW-1)'(1);
    h0         = valid_q[0] && tag_q[0] == tag;
    h1         = valid_q[1] && tag_q[1] == tag;
    hit        = bus.rom_cs && (h0 || h1);
    word       = h0 ? data_q[0] : data_q[1];
    nxt_cached = (valid_q[0] && tag_q[0] == nxt) || (valid_q[1] && tag_q[1] == nxt);
  end
  assign bus.rom_ok   = hit;
  assign bus.rom_data = hit ? (bus.rom_addr[0] ? word[15:8] : word[7:0]) : 8'hFF;
  assign bus.sd_req   = req_q;
  assign bus.sd_addr  = addr_q;
  always_comb begin
    st_d      = st_q;
    req_d     = req_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    tag_d     = tag_q;
    data_d    = data_q;
    lru_d     = hit ? h0 : lru_q;
    // a flush while a fetch is outstanding poisons that fetch's data
    discard_d = (st_q == WAIT && bus.sd_dok) ? 1'b0 : discard_q | (bus.flush && st_q != IDLE);
    case (st_q)
      IDLE: begin
        if (bus.rom_cs && !hit) begin
          addr_d = tag;
          req_d  = 1'b1;
          st_d   = REQ;
        end else if (PREFETCH && hit && !nxt_cached) begin
          addr_d = nxt;
          req_d  = 1'b1;
          st_d   = REQ;
        end
      end
      REQ: begin
        if (bus.sd_ack) begin
          req_d = 1'b0;
          st_d  = WAIT;
        end
      end
      WAIT: begin
        if (bus.sd_dok) begin
          st_d = IDLE;
          if (!discard_q && !bus.flush) begin
            valid_d[lru_q] = 1'b1;
            tag_d[lru_q]   = addr_q;
            data_d[lru_q]  = bus.sd_data;
            lru_d          = ~lru_q;
          end
        end
      end
      default: st_d = IDLE;
    endcase
    if (bus.flush) valid_d = '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= IDLE;
      req_q     <= 1'b0;
      addr_q    <= '0;
      valid_q   <= '0;
      tag_q     <= '{default: '0};
      data_q    <= '{default: '0};
      lru_q     <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
      lru_q     <= lru_d;
      discard_q <= discard_d;
    end
  end
endmodule

// File: tb/tb_jt63701_romrq.sv
// tb_jt63701_romrq: directed scenarios then random traffic, checked against a cache/fetch reference model.
module tb_jt63701_romrq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  jt63701_romrq_if #(.AW(14)) bus();
  jt63701_romrq #(.AW(14), .PREFETCH(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  // reference: which ROM words are cached, the replacement victim, and the one outstanding fetch
  logic        mv [2];
  logic [12:0] mt [2];
  logic        mlru, busy, acked, disc;
  logic [12:0] maddr;
  logic        cs_i, fl_i, ak_i, dk_i;
  logic [13:0] a_i;
  function automatic logic [15:0] rom_word(input logic [12:0] w);
    return 16'hBEEF ^ (16'(w) * 16'h9E37);
  endfunction
  function automatic int find(input logic [12:0] t);
    for (int i = 0; i < 2; i++) if (mv[i] && mt[i] == t) return i;
    return -1;
  endfunction
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic m_reset;
    mv[0] = 1'b0; mv[1] = 1'b0; mt[0] = '0; mt[1] = '0;
    mlru = 1'b0; busy = 1'b0; acked = 1'b0; disc = 1'b0; maddr = '0;
  endtask
  task automatic put(input logic cs, input logic [13:0] a, input logic fl, input logic ak, input logic dk);
    logic [15:0] w;
    int h;
    cs_i = cs; a_i = a; fl_i = fl; ak_i = ak; dk_i = dk;
    bus.rom_cs = cs; bus.rom_addr = a; bus.flush = fl; bus.sd_ack = ak; bus.sd_dok = dk;
    bus.sd_data = (busy && acked && dk) ? rom_word(maddr) : 16'($urandom);
    #1;
    h = cs ? find(a[13:1]) : -1;
    w = rom_word(a[13:1]);
    chk("rom_ok", 16'(bus.rom_ok), 16'(h >= 0));
    chk("rom_data", 16'(bus.rom_data), h < 0 ? 16'h00FF : 16'(a[0] ? w[15:8] : w[7:0]));
    chk("sd_req", 16'(bus.sd_req), 16'(busy && !acked));
    chk("sd_addr", 16'(bus.sd_addr), 16'(maddr));
  endtask
  task automatic tick;
    int h;
    logic [12:0] t, nt;
    logic ol;
    @(posedge clk);
    t = a_i[13:1];
    nt = t + 13'd1;
    h = cs_i ? find(t) : -1;
    ol = mlru;
    if (h >= 0) mlru = (h == 0);
    if (!busy) begin
      if (cs_i && h < 0) begin busy = 1'b1; acked = 1'b0; maddr = t; end
      else if (h >= 0 && find(nt) < 0) begin busy = 1'b1; acked = 1'b0; maddr = nt; end
    end else if (!acked) begin
      acked = ak_i;
      disc = disc | fl_i;
    end else if (dk_i) begin
      if (!disc && !fl_i) begin mv[ol] = 1'b1; mt[ol] = maddr; mlru = ~ol; end
      busy = 1'b0;
      disc = 1'b0;
    end else disc = disc | fl_i;
    if (fl_i) begin mv[0] = 1'b0; mv[1] = 1'b0; end
    #1;
  endtask
  task automatic cyc(input logic cs, input logic [13:0] a, input logic fl, input logic ak, input logic dk);
    put(cs, a, fl, ak, dk);
    tick();
  endtask
  initial begin
    logic [12:0] base, wd;
    logic cs, fl, ak, dk;
    m_reset();
    #1 rst = 1'b1;
    put(1'b1, 14'h0001, 1'b0, 1'b0, 1'b0);
    chk("reset_req", 16'(bus.sd_req), 16'h0);
    chk("reset_addr", 16'(bus.sd_addr), 16'h0);
    chk("reset_ok", 16'(bus.rom_ok), 16'h0);
    chk("reset_data", 16'(bus.rom_data), 16'h00FF);
    @(posedge clk); #1 rst = 1'b0;
    tick();
    // cold miss on byte 1: ack two cycles later, dok three after that
    cyc(1'b1, 14'h0001, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 14'h0001, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 14'h0001, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 14'h0001, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 14'h0001, 1'b0, 1'b0, 1'b1);
    put(1'b1, 14'h0001, 1'b0, 1'b0, 1'b0);
    chk("cold_ok", 16'(bus.rom_ok), 16'h1);
    chk("cold_hi", 16'(bus.rom_data), 16'h00BE);
    tick();
    put(1'b1, 14'h0000, 1'b0, 1'b0, 1'b0);
    chk("cold_lo", 16'(bus.rom_data), 16'h00EF);
    tick();
    cyc(1'b1, 14'h0000, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 14'h0000, 1'b0, 1'b0, 1'b1);
    // word 5 fill, then a hit on it prefetches word 6
    cyc(1'b1, 14'h000A, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 14'h000A, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 14'h000A, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 14'h000A, 1'b0, 1'b0, 1'b0);
    put(1'b1, 14'h000A, 1'b0, 1'b0, 1'b0);
    chk("pf_req", 16'(bus.sd_req), 16'h1);
    chk("pf_addr", 16'(bus.sd_addr), 16'h0006);
    chk("pf_ok", 16'(bus.rom_ok), 16'h1);
    tick();
    cyc(1'b1, 14'h000B, 1'b0, 1'b1, 1'b0);
    // word 9 misses while the word-6 prefetch is in flight
    put(1'b1, 14'h0012, 1'b0, 1'b0, 1'b0);
    chk("mdp_ok", 16'(bus.rom_ok), 16'h0);
    tick();
    put(1'b1, 14'h0012, 1'b0, 1'b0, 1'b0);
    chk("mdp_noreq", 16'(bus.sd_req), 16'h0);
    tick();
    cyc(1'b1, 14'h0012, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 14'h0012, 1'b0, 1'b0, 1'b0);
    put(1'b1, 14'h0012, 1'b0, 1'b0, 1'b0);
    chk("mdp_req", 16'(bus.sd_req), 16'h1);
    chk("mdp_addr", 16'(bus.sd_addr), 16'h0009);
    tick();
    cyc(1'b1, 14'h0012, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 14'h0012, 1'b0, 1'b0, 1'b1);
    put(1'b1, 14'h0012, 1'b0, 1'b0, 1'b0);
    chk("w9_ok", 16'(bus.rom_ok), 16'h1);
    tick();
    put(1'b1, 14'h000C, 1'b0, 1'b0, 1'b0);
    chk("w6_ok", 16'(bus.rom_ok), 16'h1);
    tick();
    cyc(1'b1, 14'h000C, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 14'h000C, 1'b0, 1'b0, 1'b1);
    // last word prefetches word 0
    cyc(1'b1, 14'h3FFE, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 14'h3FFE, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 14'h3FFE, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 14'h3FFF, 1'b0, 1'b0, 1'b0);
    put(1'b1, 14'h3FFF, 1'b0, 1'b0, 1'b0);
    chk("wrap_req", 16'(bus.sd_req), 16'h1);
    chk("wrap_addr", 16'(bus.sd_addr), 16'h0000);
    tick();
    cyc(1'b1, 14'h3FFF, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 14'h3FFF, 1'b0, 1'b0, 1'b1);
    // flush while waiting for data
    cyc(1'b1, 14'h0040, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 14'h0040, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 14'h0040, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 14'h0040, 1'b0, 1'b0, 1'b1);
    put(1'b1, 14'h0040, 1'b0, 1'b0, 1'b0);
    chk("fl_ok", 16'(bus.rom_ok), 16'h0);
    tick();
    put(1'b1, 14'h0040, 1'b0, 1'b0, 1'b0);
    chk("fl_req", 16'(bus.sd_req), 16'h1);
    chk("fl_addr", 16'(bus.sd_addr), 16'h0020);
    tick();
    cyc(1'b1, 14'h0040, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 14'h0040, 1'b0, 1'b0, 1'b1);
    // reset while a request is pending, then stale handshakes
    cyc(1'b1, 14'h0080, 1'b0, 1'b0, 1'b0);
    put(1'b1, 14'h0080, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_req", 16'(bus.sd_req), 16'h0);
    m_reset();
    @(posedge clk); #1 rst = 1'b0;
    cyc(1'b0, 14'h0080, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 14'h0080, 1'b0, 1'b0, 1'b1);
    put(1'b1, 14'h0080, 1'b0, 1'b0, 1'b0);
    chk("rst_ok", 16'(bus.rom_ok), 16'h0);
    tick();
    // random traffic with a well-behaved arbiter plus stray pulses
    base = 13'h1FFD;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 50 == 0) base = ($urandom % 3 == 0) ? 13'h1FFD : 13'($urandom);
      wd = base + 13'($urandom % 6);
      cs = ($urandom % 8) != 0;
      fl = ($urandom % 40) == 0;
      if (busy && !acked) begin ak = ($urandom % 3) == 0; dk = ($urandom % 6) == 0; end
      else if (busy) begin ak = ($urandom % 8) == 0; dk = ($urandom % 3) == 0; end
      else begin ak = ($urandom % 10) == 0; dk = ($urandom % 10) == 0; end
      cyc(cs, {wd, 1'($urandom)}, fl, ak, dk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/jt63701_romrq.md
# jt63701_romrq

Responder for the HD63701-compatible MCU's internal-PROM bus ($C000–$FFFF). Turns the MCU's byte-wide `rom_cs`/`rom_addr` requests into 16-bit SDRAM word fetches and answers with `rom_data`/`rom_ok`. A 2-entry word cache and optional sequential prefetch keep the MCU's wait state short. Sits between the MCU wrapper and the jtframe SDRAM arbiter slot.

## Interface
Parameters:
- `AW`, 14, MCU ROM byte-address width.
- `PREFETCH`, 1, 1 enables fetching of the next sequential word after a hit.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rom_cs` in 1: MCU is accessing ROM.
- `rom_addr` in AW: byte address.
- `rom_data` out 8: byte at `rom_addr`; 8'hFF when no hit.
- `rom_ok` out 1: `rom_data` valid for the current `rom_addr`.
- `flush` in 1: invalidate the cache (ROM reloaded).
- `sd_addr` out AW-1: SDRAM word address.
- `sd_req` out 1: fetch request, held until acknowledged.
- `sd_ack` in 1: one-cycle pulse, request accepted.
- `sd_dok` in 1: one-cycle pulse, `sd_data` valid.
- `sd_data` in 16: fetched word.

## Operation
- Word tag = `rom_addr[AW-1:1]`. Byte select: even address → `sd_data[7:0]`, odd → `[15:8]`.
- Cache: 2 entries, each with `valid`, tag (AW-1 bits) and 16-bit data, plus one LRU bit.
- `hit` = `rom_cs` && some valid entry's tag equals the current tag.
- `rom_ok` = `hit`, combinational. `rom_data` is taken from the hitting entry.
- Every registered hit sets LRU to the other entry. Fills always go into the LRU entry, which then becomes MRU.
- FSM states:
  - IDLE:
    - `rom_cs` && !hit → load `sd_addr` = tag, set `sd_req`, go to REQ with pf=0.
    - Else if PREFETCH && hit && next tag (tag+1, wraps from all-ones to 0) not cached → `sd_addr` = next tag, go to REQ with pf=1.
  - REQ: `sd_req`=1. On `sd_ack`, clear `sd_req` and go to WAIT.
  - WAIT: on `sd_dok`, write `sd_data` into the LRU entry (valid=1, tag=`sd_addr`) unless the fetch is discarded, then go to IDLE.
- Only one fetch is outstanding at a time; a prefetch is never aborted.
- A miss during a pf=1 fetch waits for it to complete, then is re-evaluated in IDLE. The prefetched word may be the one needed, giving a hit with no new request.
- `sd_ack` and `sd_dok` are ignored outside REQ and WAIT respectively. `sd_ack` and `sd_dok` in the same cycle while in REQ: treat the ack only; `sd_dok` must arrive later.
- `rom_addr` may change while `rom_cs` stays high: `rom_ok` follows combinationally, and an in-flight fetch for the old address still completes and fills.
- `flush`:
  - Clears all `valid` bits next edge, in any state.
  - If the state is REQ or WAIT, sets a discard flag: the pending `sd_dok` data is dropped (no fill), then the flag clears.
  - Flush and fill in the same cycle: flush wins.
- `rom_cs` low: no new demand fetches; no prefetch starts.

## Timing
- Reset values: `sd_req`=0, `sd_addr`=0, all `valid`=0, LRU=0, state IDLE, discard=0. Hence `rom_ok`=0 and `rom_data`=8'hFF.
- Reset mid-fetch returns to IDLE immediately. Stale `sd_ack`/`sd_dok` after reset are ignored.
- Hit: `rom_ok` is high in the same cycle `rom_addr` is presented.
- Demand miss, with miss seen at edge N (IDLE):
  - `sd_req` and `sd_addr` valid from N+1.
  - `sd_ack` sampled at edge A → `sd_req` low after A.
  - `sd_dok` sampled at edge D → entry written at D, `rom_ok` high from D+1.
  - Minimum miss latency with ack at N+1 and dok at N+2: `rom_ok` at N+3.
- `sd_addr` is stable from request until `sd_dok`.

## Test plan
- Cold miss: reset, `rom_cs`=1, `rom_addr`=14'h0001, ack 2 cycles later, dok 3 cycles after that with `sd_data`=16'hBEEF.
  - → single `sd_req` with `sd_addr`=0; `rom_ok` high the cycle after dok; `rom_data`=8'hBE.
  - Then address 14'h0000 → `rom_data`=8'hEF with `rom_ok` the same cycle and no new request.
- Prefetch: PREFETCH=1, hit on word 5 → request with `sd_addr`=6 while `rom_ok` stays high. After the fill, address 14'h000C hits with no request.
- Wrap: hit on word 13'h1FFF → prefetch `sd_addr`=0.
- Miss during prefetch: a miss on word 9 while the prefetch of word 6 is in WAIT → no second `sd_req` until the word-6 dok; then a request for 9. Word 6 lands in LRU, word 9 evicts the other entry.
- Flush in WAIT: assert `flush` before dok → `valid` bits cleared, dok data not written, `rom_ok` stays low, and a fresh request is issued for the still-pending address.
- Reset during REQ: `sd_req` drops asynchronously. A late `sd_ack`/`sd_dok` after reset release produces no fill and `rom_ok`=0.
